phy_urx: RTL

UART receive PHY for the commu path. It is the line-side counterpart of `phy_utx`: it deserialises the 8-bit UART frames that `phy_utx` produces, timed by the shared 1 µs `pluse_us` tick. It presents each received byte as a one-cycle `rx_vld` strobe to the commu protocol logic and flags frames that fail the stop-bit check or, when enabled, the parity check.

---
 rtl/phy_uart_defs.sv | 34 +++
 rtl/phy_urx_sync.sv | 31 +++
 rtl/phy_urx.sv | 112 +++++++++++
 3 files changed

// File: rtl/phy_uart_defs.sv
// Shared UART definitions for phy_utx / phy_urx: bit-cell sample points on the
// 1 us pluse_us grid, frame length, and receiver state encodings.
package phy_uart_defs;

  localparam logic [7:0] URX_S_START = 8'd5;
  localparam logic [7:0] URX_S_D0    = 8'd13;
  localparam logic [7:0] URX_S_D1    = 8'd22;
  localparam logic [7:0] URX_S_D2    = 8'd31;
  localparam logic [7:0] URX_S_D3    = 8'd39;
  localparam logic [7:0] URX_S_D4    = 8'd48;
  localparam logic [7:0] URX_S_D5    = 8'd57;
  localparam logic [7:0] URX_S_D6    = 8'd65;
  localparam logic [7:0] URX_S_D7    = 8'd74;
  localparam logic [7:0] URX_S_PAR   = 8'd83;
  localparam logic [7:0] URX_S_STOP  = 8'd91;

  localparam int URX_FRAME_US = 92;

  typedef enum logic [2:0] {
    URX_IDLE    = 3'd0,
    URX_START   = 3'd1,
    URX_DATA    = 3'd2,
    URX_PAR     = 3'd3,
    URX_STOP    = 3'd4,
    URX_WAIT_HI = 3'd5
  } urx_state_e;

  function automatic logic is_data_sample(input logic [7:0] c);
    return (c == URX_S_D0) || (c == URX_S_D1) || (c == URX_S_D2) ||
           (c == URX_S_D3) || (c == URX_S_D4) || (c == URX_S_D5) ||
           (c == URX_S_D6) || (c == URX_S_D7);
  endfunction

endpackage

// File: rtl/phy_urx_sync.sv
// Metastability synchroniser for the asynchronous uart_rx line plus
// falling-edge detect on the synchronised level.
module phy_urx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic uart_rx,
  output logic rxd_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_d;

  // Chain resets to the idle-high level so reset release cannot fake an edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rxd_d  <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      rxd_d  <= rxd_s;
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign fall  = rxd_d & ~rxd_s;

endmodule

// File: rtl/phy_urx.sv
// UART receive PHY: samples 8-bit frames on the pluse_us grid and strobes
// rx_vld / rx_err. Define PHY_URX_PARITY_EN to check the even-parity slot.
module phy_urx
  import phy_uart_defs::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pluse_us,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_err,
  output logic       rx_busy
);

  logic       rxd_s;
  logic       fall;
  urx_state_e state, state_nxt;
  logic [7:0] cnt_us;
  logic [7:0] shreg;
  logic       vld_nxt;
  logic       err_nxt;
  logic       par_err;

  phy_urx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .rxd_s   (rxd_s),
    .fall    (fall)
  );

`ifdef PHY_URX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      par_bit <= 1'b0;
    end else if (state == URX_PAR && pluse_us && cnt_us == URX_S_PAR) begin
      par_bit <= rxd_s;
    end
  end

  assign par_err = par_bit ^ (^shreg);
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_nxt = state;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      URX_IDLE:  if (fall) state_nxt = URX_START;
      URX_START: if (pluse_us && cnt_us == URX_S_START)
                   state_nxt = rxd_s ? URX_IDLE : URX_DATA;
      URX_DATA:  if (pluse_us && cnt_us == URX_S_D7) state_nxt = URX_PAR;
      URX_PAR:   if (pluse_us && cnt_us == URX_S_PAR) state_nxt = URX_STOP;
      URX_STOP: begin
        if (pluse_us && cnt_us == URX_S_STOP) begin
          if (!rxd_s) begin
            err_nxt   = 1'b1;
            state_nxt = URX_WAIT_HI;
          end else if (par_err) begin
            err_nxt   = 1'b1;
            state_nxt = URX_IDLE;
          end else begin
            vld_nxt   = 1'b1;
            state_nxt = URX_IDLE;
          end
        end
      end
      // A break or stuck-low line must not be taken as a fresh start bit.
      URX_WAIT_HI: if (rxd_s) state_nxt = URX_IDLE;
      default:     state_nxt = URX_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state   <= URX_IDLE;
      cnt_us  <= 8'd0;
      shreg   <= 8'd0;
      rx_data <= 8'h00;
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rx_vld <= vld_nxt;
      rx_err <= err_nxt;
      if (state_nxt == URX_IDLE) begin
        cnt_us <= 8'd0;
      end else if (state == URX_IDLE) begin
        cnt_us <= 8'd1;
      end else if (pluse_us) begin
        cnt_us <= cnt_us + 8'd1;
      end
      if (state == URX_DATA && pluse_us && is_data_sample(cnt_us)) begin
        shreg <= {rxd_s, shreg[7:1]};
      end
      if (vld_nxt) begin
        rx_data <= shreg;
      end
    end
  end

  assign rx_busy = (state != URX_IDLE);

endmodule
